rf_read_arbiter: RTL and testbench

// - Shares one physical register-file read port among NUM_REQ read requesters, e.g. rs1/rs2 of parallel branch-path read stages.
// - Round-robin grant; one outstanding read at a time.
// - Holds rf_en/rf_addr until the register file signals done, then returns done/valid/value to the winner.
// - A timeout counter bounds every transaction.

---
 rtl/rf_read_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rf_read_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: shares one register-file read port among NUM_REQ requesters.
// Round-robin grant with a single outstanding read. rf_en/rf_addr are held until
// rf_done; the result is then returned to the winner. A timeout bounds every
// transaction, and dropping req_en for the granted requester aborts it.
//
// Ports:
//   clk        clock, posedge
//   rst        synchronous active-low reset
//   req_en     per-requester level request, held until rsp_done
//   req_addr   requester i address in bits [i*ADDR_W +: ADDR_W]
//   rsp_done   completion pulse per requester (one-hot unless coalescing)
//   rsp_valid  data valid, qualified by rsp_done
//   rsp_value  read data, qualified by rsp_done
//   rf_en      physical port request
//   rf_addr    physical port address
//   rf_done    register-file completion, sampled while rf_en=1
//   rf_valid   register-file data valid
//   rf_value   register-file data
//
// Build option: define RF_ARB_COALESCE_EN to complete every pending requester
// whose address matches the granted one in the same transaction.
module rf_read_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic                      rsp_valid,
    output logic [XLEN-1:0]           rsp_value,
    output logic                      rf_en,
    output logic [ADDR_W-1:0]         rf_addr,
    input  logic                      rf_done,
    input  logic                      rf_valid,
    input  logic [XLEN-1:0]           rf_value
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic [SUM_W-1:0]  idx;
    logic [IDX_W-1:0]  ptr_inc;
    logic [NUM_REQ-1:0] share;
    logic              complete;

    // Unpack the flat address bus
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end

    // Round-robin pick: first set request scanning from ptr with wrap
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = SUM_W'(ptr_q) + SUM_W'(k);
            if (idx >= SUM_W'(NUM_REQ)) begin
                idx = idx - SUM_W'(NUM_REQ);
            end
            if (!found && req_en[idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

    // Pointer after this grant, wrapping at NUM_REQ-1
    assign ptr_inc = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

`ifdef RF_ARB_COALESCE_EN
    // Pending requesters reading the same register ride along on the completion
    always_comb begin
        share = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            share[i] = req_en[i] && (addr_arr[i] == addr_arr[grant_q]);
        end
    end
`else
    assign share = '0;
`endif

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        tmo_d     = tmo_q;
        complete  = 1'b0;
        rsp_done  = '0;
        rsp_valid = 1'b0;
        rsp_value = '0;
        rf_en     = 1'b0;
        rf_addr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = ST_BUSY;
                    tmo_d   = '0;
                end
            end
            ST_BUSY: begin
                rf_en   = 1'b1;
                rf_addr = addr_arr[grant_q];
                // A flushed requester never receives a completion, even with rf_done
                if (!req_en[grant_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_inc;
                end else if (rf_done) begin
                    complete  = 1'b1;
                    rsp_valid = rf_valid;
                    rsp_value = rf_value;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    complete = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (complete) begin
                    rsp_done = (NUM_REQ'(1) << grant_q) | share;
                    state_d  = ST_IDLE;
                    ptr_d    = ptr_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset abandons any transaction in flight without a response
        if (!rst) begin
            rsp_done  = '0;
            rsp_valid = 1'b0;
            rsp_value = '0;
            rf_en     = 1'b0;
            rf_addr   = '0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Testbench for rf_read_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_rf_read_arbiter;

    localparam int N   = 4;
    localparam int AW  = 5;
    localparam int XW  = 32;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_en;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      rsp_done;
    logic              rsp_valid;
    logic [XW-1:0]     rsp_value;
    logic              rf_en;
    logic [AW-1:0]     rf_addr;
    logic              rf_done;
    logic              rf_valid;
    logic [XW-1:0]     rf_value;

    logic [AW-1:0]     addr [N];

    rf_read_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .XLEN(XW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_addr(req_addr),
        .rsp_done(rsp_done), .rsp_valid(rsp_valid), .rsp_value(rsp_value),
        .rf_en(rf_en), .rf_addr(rf_addr),
        .rf_done(rf_done), .rf_valid(rf_valid), .rf_value(rf_value)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the port, how long it has waited, where RR resumes
    bit  m_busy;
    int  m_owner, m_age, m_ptr;

    logic [N-1:0]  e_done, o_done;
    logic          e_valid, o_valid, e_en, o_en;
    logic [XW-1:0] e_value, o_value;
    logic [AW-1:0] e_addr, o_addr;

    // One clock cycle: drive, predict, compare, then advance the model
    task automatic step(input logic r, input logic [N-1:0] en, input logic d,
                        input logic v, input logic [XW-1:0] val);
        bit fin;
        @(negedge clk);
        rst = r; req_en = en; rf_done = d; rf_valid = v; rf_value = val;
        #1;
        fin = 0;
        e_done = '0; e_valid = 1'b0; e_value = '0; e_en = 1'b0; e_addr = '0;
        if (r && m_busy) begin
            e_en   = 1'b1;
            e_addr = addr[m_owner];
            if (!en[m_owner]) begin
                fin = 1;
            end else if (d || m_age == TMO - 1) begin
                fin = 1;
                e_done[m_owner] = 1'b1;
`ifdef RF_ARB_COALESCE_EN
                for (int i = 0; i < N; i++)
                    if (en[i] && addr[i] == addr[m_owner]) e_done[i] = 1'b1;
`endif
                if (d) begin
                    e_valid = v;
                    e_value = val;
                end
            end
        end
        o_done = rsp_done; o_valid = rsp_valid; o_value = rsp_value;
        o_en = rf_en; o_addr = rf_addr;
        chk("rsp_done", 64'(o_done), 64'(e_done));
        chk("rf_en", 64'(o_en), 64'(e_en));
        chk("rf_addr", 64'(o_addr), 64'(e_addr));
        if (e_done != 0 || !m_busy || !r) begin
            chk("rsp_valid", 64'(o_valid), 64'(e_valid));
            chk("rsp_value", 64'(o_value), 64'(e_value));
        end
        @(posedge clk);
        if (!r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && en[(m_ptr + k) % N]) begin
                    m_busy = 1; m_owner = (m_ptr + k) % N; m_age = 0;
                end
            end
        end else if (fin) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else begin
            m_age++;
        end
    endtask

    logic [N-1:0] act;
    logic [N-1:0] last_done;
    logic [N-1:0] rr_exp;
    logic         rdone;

    initial begin
        rst = 1'b0; req_en = '0; rf_done = 1'b0; rf_valid = 1'b0; rf_value = '0;
        for (int i = 0; i < N; i++) addr[i] = AW'(10 + i);
        m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0;

        // Reset held with all requests and rf_done high
        repeat (3) step(1'b0, 4'b1111, 1'b1, 1'b1, 32'h1);
        chk("rst_rf_en", 64'(o_en), 64'(0));
        chk("rst_rsp_done", 64'(o_done), 64'(0));
        step(1'b1, 4'b1111, 1'b0, 1'b0, 32'h0);
        step(1'b1, 4'b1111, 1'b1, 1'b1, 32'h1234);
        chk("first_grant_addr", 64'(o_addr), 64'(10));
        chk("first_grant_done", 64'(o_done), 64'(4'b0001));
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Single read completing on the third BUSY cycle
        addr[1] = AW'(7);
        step(1'b1, 4'b0010, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 4'b0010, 1'b0, 1'b0, 32'h0);
            chk("single_en", 64'(o_en), 64'(1));
            chk("single_addr", 64'(o_addr), 64'(7));
        end
        step(1'b1, 4'b0010, 1'b1, 1'b1, 32'hDEADBEEF);
        chk("single_addr3", 64'(o_addr), 64'(7));
        chk("single_done", 64'(o_done), 64'(4'b0010));
        chk("single_value", 64'(o_value), 64'(32'hDEADBEEF));
        chk("single_valid", 64'(o_valid), 64'(1));
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Round-robin with all requests held and rf_done tied high
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 4'b1111, 1'b1, 1'b1, 32'(c));
            rr_exp = (c % 2 == 1) ? N'(1 << ((c / 2) % N)) : '0;
            chk("rr_order", 64'(o_done), 64'(rr_exp));
        end
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Timeout with rf_done never asserted
        step(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= TMO; c++) begin
            step(1'b1, 4'b0100, 1'b0, 1'b1, 32'hFFFF);
            if (c < TMO) chk("tmo_early_done", 64'(o_done), 64'(0));
        end
        chk("tmo_done", 64'(o_done), 64'(4'b0100));
        chk("tmo_valid", 64'(o_valid), 64'(0));
        chk("tmo_value", 64'(o_value), 64'(0));
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);
        chk("tmo_en_after", 64'(o_en), 64'(0));

        // Abort on BUSY cycle 2, colliding with rf_done
        addr[0] = AW'(5);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0);
        step(1'b1, 4'b0000, 1'b1, 1'b1, 32'hAAAA);
        chk("abort_done", 64'(o_done), 64'(0));
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);
        chk("abort_en_after", 64'(o_en), 64'(0));

        // Reset in the middle of a transaction
        step(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0);
        step(1'b0, 4'b0001, 1'b1, 1'b1, 32'hBBBB);
        chk("rst_busy_done", 64'(o_done), 64'(0));
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);
        chk("rst_busy_en", 64'(o_en), 64'(0));
        chk("rst_busy_addr", 64'(o_addr), 64'(0));

        // Two requesters on the same register
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
        addr[0] = AW'(3); addr[2] = AW'(3);
        step(1'b1, 4'b0101, 1'b1, 1'b1, 32'hC0DE);
        step(1'b1, 4'b0101, 1'b1, 1'b1, 32'hC0DE);
`ifdef RF_ARB_COALESCE_EN
        chk("coal_done", 64'(o_done), 64'(4'b0101));
        step(1'b1, 4'b0000, 1'b1, 1'b1, 32'hC0DE);
        chk("coal_after", 64'(o_done), 64'(0));
`else
        chk("coal_done0", 64'(o_done), 64'(4'b0001));
        step(1'b1, 4'b0100, 1'b1, 1'b1, 32'hC0DE);
        step(1'b1, 4'b0100, 1'b1, 1'b1, 32'hC0DE);
        chk("coal_done2", 64'(o_done), 64'(4'b0100));
`endif
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Randomized traffic: requesters hold until done, occasionally flush
        act = '0;
        last_done = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (act[i] && last_done[i]) begin
                    act[i] = 1'b0;
                end else if (act[i] && $urandom_range(39) == 0) begin
                    act[i] = 1'b0;
                end else if (!act[i] && $urandom_range(2) == 0) begin
                    act[i]  = 1'b1;
                    addr[i] = AW'($urandom_range(3));
                end
            end
            rdone = ((c / 200) % 2 == 0) ? ($urandom_range(1) == 1) : ($urandom_range(24) == 0);
            step(($urandom_range(149) != 0), act, rdone, 1'($urandom_range(1)), $urandom);
            last_done = e_done;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
